// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiply sequencer.
package mul_pkg;

  // Default datapath geometry; instances may override WIDTH/BITS.
  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_BITS  = 1;
  localparam int unsigned ITER      = MUL_WIDTH / MUL_BITS;

  // Sequencer state encoding (kept as fixed constants for legacy compatibility).
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Iteration counter width; never below one bit so a single-step
  // configuration still has a valid counter.
  function automatic int unsigned cnt_width(input int unsigned iter);
    if (iter > 1) begin
      return $clog2(iter);
    end
    return 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(ITER);

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add step retiring BITS multiplier bits.
module mul_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BITS  = 1
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0] mplier_next
);

  // Add each selected shifted multiplicand; sums wrap modulo 2^WIDTH.
  always_comb begin
    acc_next = acc;
    for (int unsigned i = 0; i < BITS; i++) begin
      if (mplier[i]) begin
        acc_next = acc_next + (mcand << i);
      end
    end
    mcand_next  = mcand << BITS;
    mplier_next = mplier >> BITS;
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/MLA sequencer for the EX stage: FSM, operand registers,
// result register and the stall/done decode toward the hazard unit.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BITS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             MlaE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] AccE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] MulResultE
);

  localparam int unsigned ITER_L = WIDTH / BITS;
  localparam int unsigned CW     = cnt_width(ITER_L);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITER_L - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mcand_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             accept;

  assign accept = (state == IDLE) && StartE && !FlushE;

  mul_step #(
    .WIDTH (WIDTH),
    .BITS  (BITS)
  ) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (acc_nxt),
    .mcand_next  (mcand_nxt),
    .mplier_next (mplier_nxt)
  );

  // FSM, counter and operand/result registers; flush aborts without
  // touching the result, reset additionally clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      MulResultE <= '0;
    end else if (FlushE) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (StartE) begin
            mcand  <= SrcAE;
            mplier <= SrcBE;
            acc    <= MlaE ? AccE : '0;
            cnt    <= CNT_LOAD;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          if (cnt == '0) begin
            MulResultE <= acc_nxt;
            state      <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          // StartE still reflects the instruction just finished; ignore it.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall while accepting or iterating; done is suppressed if EX is flushed.
  always_comb begin
    BusyE = accept || (state == RUN);
    DoneE = (state == DONE) && !FlushE;
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer (BITS=1 and BITS=4 instances).
module tb_mul_sequencer;

  logic        clk;
  logic        reset;
  logic        start1, mla1, flush1;
  logic [31:0] a1, b1, c1;
  logic        busy1, done1;
  logic [31:0] res1;
  logic        start4, mla4, flush4;
  logic [31:0] a4, b4, c4;
  logic        busy4, done4;
  logic [31:0] res4;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q4[$];
  int          total;
  int          bad;
  int          cyc;
  int          n_done1;
  logic [31:0] last_res1;

  mul_sequencer #(.WIDTH(32), .BITS(1)) dut1 (
    .clk(clk), .reset(reset), .StartE(start1), .MlaE(mla1), .FlushE(flush1),
    .SrcAE(a1), .SrcBE(b1), .AccE(c1),
    .BusyE(busy1), .DoneE(done1), .MulResultE(res1)
  );

  mul_sequencer #(.WIDTH(32), .BITS(4)) dut4 (
    .clk(clk), .reset(reset), .StartE(start4), .MlaE(mla4), .FlushE(flush4),
    .SrcAE(a4), .SrcBE(b4), .AccE(c4),
    .BusyE(busy4), .DoneE(done4), .MulResultE(res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive1(input logic st, input logic m, input logic fl,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
    start1 = st; mla1 = m; flush1 = fl; a1 = av; b1 = bv; c1 = cv;
  endtask

  // Scoreboard pop on every observed done pulse.
  task automatic mon();
    exp_t e;
    if (done1) begin
      n_done1++;
      if (q1.size() == 0) begin
        chk("done1_unexpected", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("res1", res1, e.res);
        chk("done1_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done4) begin
      if (q4.size() == 0) begin
        chk("done4_unexpected", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("res4", res4, e.res);
        chk("done4_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  // One BITS=1 op: accept at k=0, StartE held through DONE (k=33),
  // operands scrambled after accept.
  task automatic do_mul1(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] cv, input logic m);
    exp_t        e;
    logic [31:0] exp_res;
    exp_res = av * bv + (m ? cv : 32'd0);
    for (int k = 0; k <= 33; k++) begin
      cycle_begin();
      if (k == 0) drive1(1'b1, m, 1'b0, av, bv, cv);
      else drive1(1'b1, 1'($urandom_range(0, 1)), 1'b0, $urandom, $urandom, $urandom);
      #1;
      if (k == 0) begin
        e.res = exp_res;
        e.cyc = cyc + 33;
        q1.push_back(e);
      end
      chk("busy1", 32'(busy1), 32'(k <= 32));
      chk("done1", 32'(done1), 32'(k == 33));
      if (k == 1 || k == 32) chk("res1_hold", res1, last_res1);
      mon();
    end
    last_res1 = exp_res;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      cycle_begin();
      drive1(1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
      #1;
      chk("idle_busy1", 32'(busy1), 32'd0);
      chk("idle_res1", res1, last_res1);
      mon();
    end
  endtask

  initial begin
    exp_t e;
    int   d0;
    total = 0; bad = 0; cyc = 0; n_done1 = 0; last_res1 = '0;
    reset = 1'b1;
    drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
    start4 = 1'b0; mla4 = 1'b0; flush4 = 1'b0; a4 = '0; b4 = '0; c4 = '0;
    @(posedge clk);

    // Reset for 2 cycles, then 5 idle cycles.
    for (int k = 0; k < 7; k++) begin
      cycle_begin();
      if (k == 2) reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_res", res1, 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      mon();
    end

    // Plain MUL and MLA with wrap-around.
    do_mul1(32'd7, 32'd6, 32'd0, 1'b0);
    idle_cycles(1);
    do_mul1(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1);
    idle_cycles(2);

    // Flush during RUN cycle 10 aborts the 3x5 without a result.
    for (int k = 0; k <= 40; k++) begin
      cycle_begin();
      if (k == 0) drive1(1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0);
      else drive1(1'b0, 1'b0, (k == 10), $urandom, $urandom, $urandom);
      #1;
      if (k == 0) begin
        e.res = 32'd15; e.cyc = cyc + 33; q1.push_back(e);
      end
      if (k == 10) begin
        chk("flush_busy_run", 32'(busy1), 32'd1);
        void'(q1.pop_back());
      end
      if (k == 11) chk("flush_busy_after", 32'(busy1), 32'd0);
      if (k > 10) chk("flush_no_done", 32'(done1), 32'd0);
      if (k == 11 || k == 40) chk("flush_res_hold", res1, last_res1);
      mon();
    end
    do_mul1(32'd2, 32'd2, 32'd0, 1'b0);
    idle_cycles(1);

    // Back-to-back: 3x3 then 4x4 accepted in cycle 34, exactly two pulses.
    d0 = n_done1;
    do_mul1(32'd3, 32'd3, 32'd0, 1'b0);
    do_mul1(32'd4, 32'd4, 32'd0, 1'b0);
    idle_cycles(3);
    chk("b2b_pulses", 32'(n_done1 - d0), 32'd2);

    // BITS=4 instance: done at cycle 9.
    for (int k = 0; k <= 11; k++) begin
      cycle_begin();
      start4 = (k <= 9);
      a4 = (k == 0) ? 32'h0001_0000 : $urandom;
      b4 = (k == 0) ? 32'h0001_0001 : $urandom;
      c4 = $urandom;
      drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      if (k == 0) begin
        e.res = 32'h0001_0000; e.cyc = cyc + 9; q4.push_back(e);
      end
      chk("busy4", 32'(busy4), 32'(k <= 8));
      chk("done4", 32'(done4), 32'(k == 9));
      mon();
    end
    start4 = 1'b0;

    // Reset mid-operation aborts and clears the result.
    for (int k = 0; k <= 40; k++) begin
      cycle_begin();
      reset = (k == 6);
      if (k == 0) drive1(1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0);
      else drive1(1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
      #1;
      if (k == 0) begin
        e.res = 32'd81; e.cyc = cyc + 33; q1.push_back(e);
      end
      if (k == 6) q1.delete();
      if (k == 3) chk("rst_mid_busy", 32'(busy1), 32'd1);
      if (k == 7) begin
        chk("rst_mid_res", res1, 32'd0);
        chk("rst_mid_busy_after", 32'(busy1), 32'd0);
      end
      if (k > 6) chk("rst_mid_no_done", 32'(done1), 32'd0);
      mon();
    end
    reset = 1'b0;

    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q4_empty", 32'(q4.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiply sequencer in the Execute stage of the pipelined ARM core. It accepts MUL/MLA operands from the EX datapath and computes the low WIDTH bits of the product, plus an optional accumulate, over multiple cycles. It raises a stall request that the hazard unit ORs into its StallF/StallD/StallE logic, and it honours FlushE as an abort.

## Interface
- WIDTH, 32: operand and result width.
- BITS, 1: multiplier bits retired per RUN cycle. Legal values are 1, 2 and 4; WIDTH must be a multiple of BITS. ITER = WIDTH/BITS.
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- StartE  in  1  a condition-passed MUL/MLA is in EX.
- MlaE  in  1  accumulate variant; sampled at accept.
- FlushE  in  1  EX flush from hazardunit; aborts any operation.
- SrcAE  in  WIDTH  multiplicand.
- SrcBE  in  WIDTH  multiplier.
- AccE  in  WIDTH  addend, used when MlaE=1.
- BusyE  out  1  stall request to hazardunit; combinational.
- DoneE  out  1  one-cycle pulse; MulResultE is valid.
- MulResultE  out  WIDTH  registered product; holds its value until the next accept.

## Operation
- FSM states: IDLE, RUN, DONE. The state register, iteration counter and operand registers use synchronous reset.
- Reset values: state=IDLE, BusyE=0, DoneE=0, MulResultE=0, counter=0.
- IDLE:
  - With StartE=1 and FlushE=0 (accept): latch Mcand=SrcAE, Mplier=SrcBE, Acc=(MlaE ? AccE : 0), counter=ITER-1, then go to RUN.
  - Otherwise stay in IDLE.
- RUN: each cycle does one step:
  - Acc += sum over i<BITS of (Mplier[i] ? Mcand<<i : 0).
  - Mcand <<= BITS; Mplier >>= BITS.
  - All sums are modulo 2^WIDTH; carries out of the top bit are discarded.
  - counter decrements. When counter==0, load MulResultE with the final Acc and go to DONE.
- DONE: DoneE=1, BusyE=0 and next state is IDLE. StartE is ignored in this state, because the same instruction is still in EX.
- BusyE = (IDLE & StartE & ~FlushE) | RUN.
- FlushE=1 in any state: next state is IDLE, and no DoneE is produced for the aborted operation. MulResultE keeps its previous value. FlushE takes priority over StartE.
- reset=1 in mid-operation behaves like FlushE and additionally clears MulResultE.
- Operands change while RUN: no effect, because only the latched copies are used.
- Latency is fixed; there is no early termination on zero operands.

## Timing
- Accept at cycle 0. RUN occupies cycles 1..ITER. DONE is at cycle ITER+1.
- BusyE is high in cycles 0..ITER, so EX is stalled for ITER+1 cycles. The instruction leaves EX at the end of cycle ITER+1.
- BITS=1, WIDTH=32: DoneE at cycle 33. BITS=4: DoneE at cycle 9.
- Back-to-back MULs:
  - The second MUL enters EX in cycle ITER+2 with the FSM in IDLE, and is accepted that cycle.
  - There is no dead cycle between the two operations.
  - There is no double-accept of the first MUL.
- MulResultE is registered and is stable from the DONE cycle onward. The EX result mux selects it when DoneE=1.

## Structure
- Shared package mul_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam ITER;
  - counter width $clog2(ITER).
- Sub-module mul_step: purely combinational, one BITS-bit shift-add step (Acc, Mcand, Mplier in; next values out). It is reusable by a future radix-4 Booth variant.
- mul_sequencer holds the FSM, counter, operand/result registers and BusyE/DoneE decode.

## Test plan
- Reset held 2 cycles, then StartE=0 for 5 cycles -> BusyE=0, DoneE=0, MulResultE=0 throughout.
- MUL SrcAE=7, SrcBE=6, BITS=1, StartE held high -> BusyE high cycles 0..32; DoneE only at cycle 33 with MulResultE=42; BusyE=0 at cycle 33.
- MLA SrcAE=0xFFFFFFFF, SrcBE=2, AccE=5 -> DoneE at cycle 33 with MulResultE=0x00000003 (wrap-around).
- MUL 3×5 started, FlushE=1 at RUN cycle 10 -> BusyE=0 at cycle 11, no DoneE ever, MulResultE unchanged. A new MUL 2×2 then accepted -> 4 after 34 cycles.
- Back-to-back: MUL 3×3 with StartE held through DONE, then MUL 4×4 presented in cycle 34 -> DoneE pulses at 33 (9) and 67 (16), exactly two pulses.
- BITS=4, SrcAE=0x00010000, SrcBE=0x00010001 -> DoneE at cycle 9, MulResultE=0x00010000. BusyE high for cycles 0..8.
